// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// and the select codes consumed by the npc, gpr, alu and ext datapath blocks.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam int WAIT_W = 8;

  // One-hot instruction class; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR word to one-hot class plus illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output instr_cls_t  cls_o,
  output logic        illegal_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign unused_instr_bits = ^instr_i[25:6];

  always_comb begin
    cls_o = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb, drives datapath
// selects and strobes, times out stalled memory handshakes, counts retirements.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             gpr_we,
  output logic [1:0]       gpr_dst,
  output logic [1:0]       gpr_src,
  output logic [2:0]       alu_op,
  output logic             alu_bsel,
  output logic [1:0]       ext_op,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [WAIT_W-1:0] TMO_C = WAIT_W'(TMO);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q;
  logic              retire;
  logic              wait_expired;
  instr_cls_t        cls;
  logic              is_illegal;
  logic [2:0]        alu_op_c;
  logic              alu_bsel_c;
  logic [1:0]        ext_op_c;

  mc_decode u_decode (
    .instr_i   (instr),
    .cls_o     (cls),
    .illegal_o (is_illegal)
  );

  assign wait_expired = (wait_q == TMO_C);
  assign state_o      = state_q;
  assign retired      = retired_q;

  // ALU/extender setup, held constant across EXEC, MEM and WB.
  always_comb begin
    alu_op_c   = ALU_ADD;
    alu_bsel_c = 1'b0;
    ext_op_c   = EXT_ZERO;
    if (cls.subu || cls.beq) alu_op_c = ALU_SUB;
    if (cls.ori) begin
      alu_op_c   = ALU_OR;
      alu_bsel_c = 1'b1;
    end
    if (cls.lui) begin
      alu_op_c   = ALU_PASSB;
      alu_bsel_c = 1'b1;
      ext_op_c   = EXT_LUI;
    end
    if (cls.lw || cls.sw) begin
      alu_bsel_c = 1'b1;
      ext_op_c   = EXT_SIGN;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    retire   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dm_we    = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = NPC_SEQ;
    gpr_we   = 1'b0;
    gpr_dst  = DST_RT;
    gpr_src  = SRC_ALU;
    alu_op   = ALU_ADD;
    alu_bsel = 1'b0;
    ext_op   = EXT_ZERO;
    illegal  = 1'b0;
    bus_err  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_SEQ;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          imem_req = 1'b0;
          bus_err  = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_DECODE: begin
        if (is_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.j || cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_J;
          retire  = 1'b1;
          state_d = ST_FETCH;
          if (cls.jal) begin
            gpr_we  = 1'b1;
            gpr_dst = DST_R31;
            gpr_src = SRC_PC4;
          end
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JR;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_op   = alu_op_c;
        alu_bsel = alu_bsel_c;
        ext_op   = ext_op_c;
        if (cls.beq) begin
          npc_sel = NPC_BEQ;
          pc_we   = zero;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        alu_op   = alu_op_c;
        alu_bsel = alu_bsel_c;
        ext_op   = ext_op_c;
        dmem_req = 1'b1;
        dm_we    = cls.sw;
        if (dmem_rdy) begin
          if (cls.sw) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          dmem_req = 1'b0;
          dm_we    = 1'b0;
          bus_err  = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_WB: begin
        alu_op   = alu_op_c;
        alu_bsel = alu_bsel_c;
        ext_op   = ext_op_c;
        gpr_we   = 1'b1;
        gpr_dst  = (cls.addu || cls.subu) ? DST_RD : DST_RT;
        gpr_src  = cls.lw ? SRC_MEM : SRC_ALU;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset masks everything so an aborted instruction leaves no side effect.
    if (rst) begin
      retire   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dm_we    = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      npc_sel  = NPC_SEQ;
      gpr_we   = 1'b0;
      gpr_dst  = DST_RT;
      gpr_src  = SRC_ALU;
      alu_op   = ALU_ADD;
      alu_bsel = 1'b0;
      ext_op   = EXT_ZERO;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs are queued from an
// instruction-level model and compared cycle by cycle against the DUT.
module tb_mc_ctrl;

  localparam int TMO_TB = 4;

  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_JR   = 2;
  localparam int C_ORI  = 3;
  localparam int C_LUI  = 4;
  localparam int C_LW   = 5;
  localparam int C_SW   = 6;
  localparam int C_BEQ  = 7;
  localparam int C_J    = 8;
  localparam int C_JAL  = 9;
  localparam int C_ILL  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        imem_rdy;
  logic        dmem_rdy;
  logic        imem_req, dmem_req, dm_we, ir_we, pc_we, gpr_we, illegal, bus_err;
  logic [1:0]  npc_sel, gpr_dst, gpr_src, ext_op;
  logic [2:0]  alu_op, state_o;
  logic        alu_bsel;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32), .TMO(TMO_TB)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .zero     (zero),
    .imem_rdy (imem_rdy),
    .dmem_rdy (dmem_rdy),
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .dm_we    (dm_we),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .npc_sel  (npc_sel),
    .gpr_we   (gpr_we),
    .gpr_dst  (gpr_dst),
    .gpr_src  (gpr_src),
    .alu_op   (alu_op),
    .alu_bsel (alu_bsel),
    .ext_op   (ext_op),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .state_o  (state_o),
    .retired  (retired)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dm_we;
    logic       ir_we;
    logic       pc_we;
    logic       gpr_we;
    logic       illegal;
    logic       bus_err;
    logic [1:0] npc;
    logic [1:0] dst;
    logic [1:0] src;
    logic [2:0] aop;
    logic       bsel;
    logic [1:0] ext;
  } obs_t;

  typedef struct {
    logic        r;
    logic        ir;
    logic        dr;
    logic        z;
    logic [31:0] ins;
    obs_t        o;
    logic [31:0] ret;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ret_m;
  logic [31:0] cur_ins;
  logic        cur_z;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic r, input logic ir, input logic dr, input obs_t o);
    rec_t e;
    e.r   = r;
    e.ir  = ir;
    e.dr  = dr;
    e.z   = cur_z;
    e.ins = cur_ins;
    e.o   = o;
    e.ret = ret_m;
    sb.push_back(e);
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic int cls_of(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    case (op)
      6'h00: begin
        if (fn == 6'h21) return C_ADDU;
        if (fn == 6'h23) return C_SUBU;
        if (fn == 6'h08) return C_JR;
        return C_ILL;
      end
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic obs_t alu_of(input int c, input logic [2:0] st);
    obs_t o;
    o = blank(st);
    case (c)
      C_SUBU, C_BEQ: o.aop = 3'b001;
      C_ORI:  begin o.aop = 3'b010; o.bsel = 1'b1; o.ext = 2'b00; end
      C_LUI:  begin o.aop = 3'b011; o.bsel = 1'b1; o.ext = 2'b10; end
      C_LW, C_SW: begin o.aop = 3'b000; o.bsel = 1'b1; o.ext = 2'b01; end
      default: o.aop = 3'b000;
    endcase
    return o;
  endfunction

  // Expected cycle trace of one instruction; fd/dd are ready delays in cycles.
  task automatic gen(input logic [31:0] ins, input logic z, input int fd, input int dd);
    int   c;
    obs_t o;
    cur_ins = ins;
    cur_z   = z;
    c = cls_of(ins);
    for (int i = 0; i < fd; i++) begin
      o = blank(3'd0);
      if (i == TMO_TB) begin
        o.bus_err = 1'b1;
        push(1'b0, 1'b0, 1'b0, o);
        return;
      end
      o.imem_req = 1'b1;
      push(1'b0, 1'b0, 1'b0, o);
    end
    o = blank(3'd0);
    o.imem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(1'b0, 1'b1, 1'b0, o);

    o = blank(3'd1);
    if (c == C_ILL) begin
      o.illegal = 1'b1;
      push(1'b0, 1'b0, 1'b0, o);
      return;
    end
    if (c == C_J || c == C_JAL || c == C_JR) begin
      o.pc_we = 1'b1;
      o.npc   = (c == C_JR) ? 2'b11 : 2'b10;
      if (c == C_JAL) begin
        o.gpr_we = 1'b1; o.dst = 2'b10; o.src = 2'b10;
      end
      push(1'b0, 1'b0, 1'b0, o);
      ret_m++;
      return;
    end
    push(1'b0, 1'b0, 1'b0, o);

    o = alu_of(c, 3'd2);
    if (c == C_BEQ) begin
      o.npc   = 2'b01;
      o.pc_we = z;
      push(1'b0, 1'b0, 1'b0, o);
      ret_m++;
      return;
    end
    push(1'b0, 1'b0, 1'b0, o);

    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i < dd; i++) begin
        o = alu_of(c, 3'd3);
        if (i == TMO_TB) begin
          o.bus_err = 1'b1;
          push(1'b0, 1'b0, 1'b0, o);
          return;
        end
        o.dmem_req = 1'b1;
        o.dm_we    = (c == C_SW);
        push(1'b0, 1'b0, 1'b0, o);
      end
      o = alu_of(c, 3'd3);
      o.dmem_req = 1'b1;
      o.dm_we    = (c == C_SW);
      push(1'b0, 1'b0, 1'b1, o);
      if (c == C_SW) begin
        ret_m++;
        return;
      end
    end

    o = alu_of(c, 3'd4);
    o.gpr_we = 1'b1;
    o.dst    = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
    o.src    = (c == C_LW) ? 2'b01 : 2'b00;
    push(1'b0, 1'b0, 1'b0, o);
    ret_m++;
  endtask

  task automatic run(input string name);
    int   n;
    rec_t e;
    obs_t g;
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst      = e.r;
      imem_rdy = e.ir;
      dmem_rdy = e.dr;
      zero     = e.z;
      instr    = e.ins;
      #1;
      g.st = state_o;
      g.imem_req = imem_req; g.dmem_req = dmem_req; g.dm_we = dm_we; g.ir_we = ir_we;
      g.pc_we = pc_we; g.gpr_we = gpr_we; g.illegal = illegal; g.bus_err = bus_err;
      g.npc = npc_sel; g.dst = gpr_dst; g.src = gpr_src;
      g.aop = alu_op; g.bsel = alu_bsel; g.ext = ext_op;
      chk($sformatf("%s.ctl%0d", name, n), 64'(g), 64'(e.o));
      chk($sformatf("%s.ret%0d", name, n), 64'(retired), 64'(e.ret));
      n++;
    end
    $display("txn %-10s instr=%h cycles=%0d retired=%0d", name, instr, n, retired);
  endtask

  logic [31:0] legal_tab [10];

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    ret_m = '0; cur_ins = '0; cur_z = 1'b0;
    legal_tab = '{32'h00221821, 32'h00221823, 32'h03E00008, 32'h342200FF, 32'h3C011234,
                  32'h8C220004, 32'hAC220004, 32'h10220003, 32'h08000010, 32'h0C000010};

    @(posedge clk);
    push(1'b1, 1'b0, 1'b0, blank(3'd0));
    push(1'b1, 1'b1, 1'b1, blank(3'd0));
    run("reset");

    gen(32'h00221821, 1'b0, 0, 0); run("addu");
    gen(32'h10220003, 1'b1, 0, 0); run("beq_t");
    gen(32'h10220003, 1'b0, 0, 0); run("beq_nt");
    gen(32'h8C220004, 1'b0, 0, 3); run("lw_d3");
    gen(32'hAC220004, 1'b0, 0, 0); run("sw");
    gen(32'h0C000010, 1'b0, 0, 0); run("jal");
    gen(32'h03E00008, 1'b0, 0, 0); run("jr");
    gen(32'h08000010, 1'b0, 0, 0); run("j");
    gen(32'h342200FF, 1'b0, 0, 0); run("ori");
    gen(32'h3C011234, 1'b0, 0, 0); run("lui");
    gen(32'h00221823, 1'b0, 2, 0); run("subu_f2");
    gen(32'hFC000000, 1'b0, 0, 0); run("ill_3f");
    gen(32'h00000000, 1'b0, 0, 0); run("ill_sll");
    gen(32'h00221821, 1'b0, 10, 0); run("ifetch_to");
    gen(32'h00221821, 1'b0, TMO_TB, 0); run("ifetch_edge");
    gen(32'h8C220004, 1'b0, 0, TMO_TB); run("lw_edge");
    gen(32'hAC220004, 1'b0, 0, 10); run("sw_to");

    // Abort a load after two MEM wait cycles; the reset cycle still shows MEM.
    gen(32'h8C220004, 1'b0, 0, 10);
    while (sb.size() > 5) void'(sb.pop_back());
    push(1'b1, 1'b0, 1'b0, blank(3'd3));
    ret_m = '0;
    run("lw_abort");
    gen(32'h00221821, 1'b0, 0, 0); run("post_rst");

    for (int k = 0; k < 20; k++) begin
      gen(legal_tab[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3));
      run("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
